// File: rtl/fetch_queue_unit.sv
// Instruction-fetch front end: owns the fetch PC, issues single in-order
// instruction-memory reads, and buffers each returned instruction (with its PC
// and PC+4) in a circular queue that decode drains via valid/deq. Supports a
// flush-and-redirect and a sticky halt that stops further fetching.
module fetch_queue_unit #(
    parameter int                ADDR_W  = 32,
    parameter int                DATA_W  = 32,
    parameter int                DEPTH   = 4,
    parameter logic [ADDR_W-1:0] PC_INIT = '0
) (
    input  logic                       CLK,
    input  logic                       nRST,
    output logic                       imemREN,
    output logic [ADDR_W-1:0]          imemaddr,
    input  logic [DATA_W-1:0]          imemload,
    input  logic                       ihit,
    input  logic                       redirect,
    input  logic [ADDR_W-1:0]          redirect_addr,
    input  logic                       halt,
    input  logic                       deq,
    output logic                       instr_valid,
    output logic [DATA_W-1:0]          instr,
    output logic [ADDR_W-1:0]          instr_pc,
    output logic [ADDR_W-1:0]          instr_npc,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);

    localparam int                PTR_W    = $clog2(DEPTH);
    localparam int                CNT_W    = PTR_W + 1;
    localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(DEPTH);
    localparam logic [ADDR_W-1:0] PC_STEP  = ADDR_W'(4);
    localparam logic [ADDR_W-1:0] WORD_MSK = {{(ADDR_W-2){1'b1}}, 2'b00};

    // Architectural state
    logic [ADDR_W-1:0] r_fpc;
    logic [PTR_W-1:0]  r_rptr;
    logic [PTR_W-1:0]  r_wptr;
    logic [CNT_W-1:0]  r_count;
    logic              r_halted;

    // Queue storage
    logic [DATA_W-1:0] r_instr [DEPTH];
    logic [ADDR_W-1:0] r_pc    [DEPTH];
    logic [ADDR_W-1:0] r_npc   [DEPTH];

    // Control and next-state wires
    logic              w_full;
    logic              w_empty;
    logic              w_ren;
    logic              w_enq;
    logic              w_pop;
    logic [ADDR_W-1:0] w_fpc_plus4;
    logic [ADDR_W-1:0] w_fpc_nxt;
    logic [PTR_W-1:0]  w_rptr_nxt;
    logic [PTR_W-1:0]  w_wptr_nxt;
    logic [CNT_W-1:0]  w_count_nxt;
    logic              w_halted_nxt;

    // Handshake decode: fetch allowed only with room, not halted, no redirect
    always_comb begin
        w_full      = (r_count == FULL_CNT);
        w_empty     = (r_count == {CNT_W{1'b0}});
        w_ren       = !w_full && !r_halted && !redirect;
        w_enq       = w_ren && ihit;
        w_pop       = deq && !w_empty && !redirect;
        w_fpc_plus4 = r_fpc + PC_STEP;
    end

    // Next-state: redirect flushes everything; otherwise pointers/count track enq/pop
    always_comb begin
        w_fpc_nxt    = r_fpc;
        w_rptr_nxt   = r_rptr;
        w_wptr_nxt   = r_wptr;
        w_count_nxt  = r_count;
        w_halted_nxt = r_halted | halt;
        if (redirect) begin
            w_fpc_nxt   = redirect_addr & WORD_MSK;
            w_rptr_nxt  = {PTR_W{1'b0}};
            w_wptr_nxt  = {PTR_W{1'b0}};
            w_count_nxt = {CNT_W{1'b0}};
        end else begin
            if (w_enq) begin
                w_fpc_nxt  = w_fpc_plus4;
                w_wptr_nxt = r_wptr + {{(PTR_W-1){1'b0}}, 1'b1};
            end else begin
                w_fpc_nxt  = r_fpc;
                w_wptr_nxt = r_wptr;
            end
            if (w_pop) begin
                w_rptr_nxt = r_rptr + {{(PTR_W-1){1'b0}}, 1'b1};
            end else begin
                w_rptr_nxt = r_rptr;
            end
            case ({w_enq, w_pop})
                2'b10:   w_count_nxt = r_count + {{(CNT_W-1){1'b0}}, 1'b1};
                2'b01:   w_count_nxt = r_count - {{(CNT_W-1){1'b0}}, 1'b1};
                default: w_count_nxt = r_count;
            endcase
        end
    end

    // Control state registers
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_fpc    <= PC_INIT;
            r_rptr   <= {PTR_W{1'b0}};
            r_wptr   <= {PTR_W{1'b0}};
            r_count  <= {CNT_W{1'b0}};
            r_halted <= 1'b0;
        end else begin
            r_fpc    <= w_fpc_nxt;
            r_rptr   <= w_rptr_nxt;
            r_wptr   <= w_wptr_nxt;
            r_count  <= w_count_nxt;
            r_halted <= w_halted_nxt;
        end
    end

    // Queue storage: write the fetched instruction tagged with its PC and PC+4
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_instr[i] <= {DATA_W{1'b0}};
                r_pc[i]    <= {ADDR_W{1'b0}};
                r_npc[i]   <= {ADDR_W{1'b0}};
            end
        end else if (w_enq) begin
            r_instr[r_wptr] <= imemload;
            r_pc[r_wptr]    <= r_fpc;
            r_npc[r_wptr]   <= w_fpc_plus4;
        end else begin
            r_instr[r_wptr] <= r_instr[r_wptr];
        end
    end

    // Output drive: head entry is shown only while valid, zero otherwise
    always_comb begin
        imemREN     = w_ren;
        imemaddr    = r_fpc;
        count       = r_count;
        full        = w_full;
        empty       = w_empty;
        instr_valid = !w_empty;
        if (!w_empty) begin
            instr     = r_instr[r_rptr];
            instr_pc  = r_pc[r_rptr];
            instr_npc = r_npc[r_rptr];
        end else begin
            instr     = {DATA_W{1'b0}};
            instr_pc  = {ADDR_W{1'b0}};
            instr_npc = {ADDR_W{1'b0}};
        end
    end

endmodule
